// File: rtl/contactor_b_driver.sv
// Coil driver for contactor B: gates close requests with the interlock permit, debounces the
// auxiliary feedback contact and supervises every transition with timeouts and latched faults.
module contactor_b_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CLOSE_TIMEOUT   = 1000,
  parameter int unsigned OPEN_TIMEOUT    = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Close_Req,
  input  logic       i_Open_Req,
  input  logic       i_Permit,
  input  logic       i_Aux_Fb,
  input  logic       i_Fault_Clr,
  output logic       o_Coil,
  output logic       o_Fb_Deb,
  output logic       o_Closed,
  output logic       o_Busy,
  output logic       o_Fault,
  output logic [1:0] o_Fault_Code
);

  localparam logic [2:0] StOpen    = 3'd0;
  localparam logic [2:0] StClosing = 3'd1;
  localparam logic [2:0] StClosed  = 3'd2;
  localparam logic [2:0] StOpening = 3'd3;
  localparam logic [2:0] StFault   = 3'd4;

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeClose  = 2'b01;
  localparam logic [1:0] CodeOpen   = 2'b10;
  localparam logic [1:0] CodeUnexp  = 2'b11;

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CloseLast = CNT_W'(CLOSE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OpenLast  = CNT_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             fb_deb_q, fb_deb_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [1:0]       code_q, code_d;
  logic             coil_q, closed_q, busy_q, fault_q;
  logic             open_cmd;

  // Debounce: a toggle needs DEBOUNCE_CYCLES consecutive disagreeing synchronised samples.
  always_comb begin
    deb_cnt_d = '0;
    fb_deb_d  = fb_deb_q;
    if (sync2_q != fb_deb_q) begin
      if (deb_cnt_q == DebLast) begin
        fb_deb_d = ~fb_deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign timer_inc = (timer_q == CntMax) ? timer_q : timer_q + 1'b1;
  assign open_cmd  = i_Open_Req | ~i_Permit;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    code_d  = code_q;
    case (state_q)
      StOpen: begin
        if (i_Close_Req & i_Permit & ~i_Open_Req & ~fb_deb_q) begin
          state_d = StClosing;
          timer_d = '0;
        end else if (fb_deb_q) begin
          state_d = StFault;
          code_d  = CodeUnexp;
        end
      end
      StClosing: begin
        timer_d = timer_inc;
        if (open_cmd) begin
          state_d = StOpening;
          timer_d = '0;
        end else if (fb_deb_q) begin
          state_d = StClosed;
        end else if (timer_q == CloseLast) begin
          state_d = StFault;
          code_d  = CodeClose;
        end
      end
      StClosed: begin
        if (open_cmd) begin
          state_d = StOpening;
          timer_d = '0;
        end else if (~fb_deb_q) begin
          state_d = StFault;
          code_d  = CodeUnexp;
        end
      end
      StOpening: begin
        timer_d = timer_inc;
        if (~fb_deb_q) begin
          state_d = StOpen;
        end else if (timer_q == OpenLast) begin
          state_d = StFault;
          code_d  = CodeOpen;
        end
      end
      StFault: begin
        // Clearing while the contact still reads closed would hide a weld.
        if (i_Fault_Clr & ~fb_deb_q) begin
          state_d = StOpen;
          code_d  = CodeNone;
        end
      end
      default: begin
        state_d = StOpen;
        code_d  = CodeNone;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      fb_deb_q  <= 1'b0;
      state_q   <= StOpen;
      timer_q   <= '0;
      code_q    <= CodeNone;
      coil_q    <= 1'b0;
      closed_q  <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= i_Aux_Fb;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      fb_deb_q  <= fb_deb_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      code_q    <= code_d;
      // Outputs are decoded from the next state so they change on the entering edge.
      coil_q    <= (state_d == StClosing) || (state_d == StClosed);
      closed_q  <= (state_d == StClosed);
      busy_q    <= (state_d == StClosing) || (state_d == StOpening);
      fault_q   <= (state_d == StFault);
    end
  end

  assign o_Coil       = coil_q;
  assign o_Fb_Deb     = fb_deb_q;
  assign o_Closed     = closed_q;
  assign o_Busy       = busy_q;
  assign o_Fault      = fault_q;
  assign o_Fault_Code = code_q;

endmodule
